// File: rtl/acc_const_table_pkg.sv
// Shared constants for the accumulator constant table: default count, sequencer states
// and the default constant map also used by the assembler.
package acc_const_pkg;

    localparam int NUM_DEFAULTS = 8;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } const_state_t;

    function automatic logic [7:0] default_const(input logic [7:0] key);
        logic [7:0] val_s;
        case (key)
            8'd0:    val_s = 8'hFF;
            8'd1:    val_s = 8'h3F;
            8'd2:    val_s = 8'h00;
            8'd3:    val_s = 8'h01;
            8'd4:    val_s = 8'h40;
            8'd5:    val_s = 8'h41;
            8'd6:    val_s = 8'h42;
            8'd7:    val_s = 8'h80;
            default: val_s = 8'h00;
        endcase
        return val_s;
    endfunction

endpackage

// File: rtl/acc_const_table_if.sv
// Read/write/control bundle of the accumulator constant table.
interface acc_const_table_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_key;
    logic [DATA_W-1:0] rd_value;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_key;
    logic [DATA_W-1:0] wr_value;
    logic              restore;
    logic              busy;
    logic              wr_err;

    modport master (
        output rd_en, rd_key, wr_en, wr_key, wr_value, restore,
        input  rd_value, rd_valid, busy, wr_err
    );

    modport slave (
        input  rd_en, rd_key, wr_en, wr_key, wr_value, restore,
        output rd_value, rd_valid, busy, wr_err
    );
endinterface

// File: rtl/acc_const_table_init_seq.sv
// Init sequencer: walks every table entry once, writing its default, after reset or restore.
module const_init_seq
    import acc_const_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restore,
    output logic              busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);
    // idx carries one spare bit so DEPTH == 2**ADDR_W finishes without wrapping
    localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    const_state_t      state_r;
    const_state_t      state_next_s;
    logic [ADDR_W:0]   idx_r;
    logic [ADDR_W:0]   idx_next_s;
    logic              busy_r;

    // Next-state and index update
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            INIT: begin
                if (idx_r == IDX_LAST) begin
                    state_next_s = IDLE;
                    idx_next_s   = '0;
                end else begin
                    idx_next_s   = idx_r + IDX_ONE;
                end
            end
            IDLE: begin
                if (restore) begin
                    state_next_s = INIT;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = INIT;
                idx_next_s   = '0;
            end
        endcase
    end

    // State, index and registered busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= INIT;
            idx_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            busy_r  <= (state_next_s == INIT);
        end
    end

    assign busy      = busy_r;
    assign init_we   = (state_r == INIT) && !reset;
    assign init_addr = idx_r[ADDR_W-1:0];
    assign init_data = DATA_W'(default_const(8'(idx_r[ADDR_W-1:0])));

endmodule

// File: rtl/acc_const_table.sv
// Writable constant table for the accumulator datapath: storage, init/runtime write mux,
// write-to-read forwarding and the registered read port.
module acc_const_table
    import acc_const_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 5,
    parameter int DEPTH         = 32,
    parameter int LOCK_DEFAULTS = 1
) (
    input logic              clk,
    input logic              reset,
    acc_const_table_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] NUM_DEF_L = (ADDR_W + 1)'(NUM_DEFAULTS);

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              busy_s;
    logic              init_we_s;
    logic [ADDR_W-1:0] init_addr_s;
    logic [DATA_W-1:0] init_data_s;
    logic              wr_in_range_s;
    logic              wr_locked_s;
    logic              wr_accept_s;
    logic              wr_reject_s;
    logic              rd_in_range_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_data_s;
    logic [DATA_W-1:0] rd_value_r;
    logic              rd_valid_r;
    logic              wr_err_r;

    const_init_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .restore   (bus.restore),
        .busy      (busy_s),
        .init_we   (init_we_s),
        .init_addr (init_addr_s),
        .init_data (init_data_s)
    );

    // Runtime write qualification and read data selection with forwarding
    always_comb begin
        wr_in_range_s = ({1'b0, bus.wr_key} < DEPTH_L);
        wr_locked_s   = (LOCK_DEFAULTS != 0) && ({1'b0, bus.wr_key} < NUM_DEF_L);
        wr_accept_s   = bus.wr_en && !reset && !busy_s && !bus.restore
                        && wr_in_range_s && !wr_locked_s;
        wr_reject_s   = bus.wr_en && !wr_accept_s;
        rd_in_range_s = ({1'b0, bus.rd_key} < DEPTH_L);
        rd_data_s     = '0;
        if (!rd_in_range_s) begin
            rd_data_s = '0;
        end else if (wr_accept_s && (bus.wr_key == bus.rd_key)) begin
            rd_data_s = bus.wr_value;
        end else begin
            rd_data_s = mem_r[bus.rd_key];
        end
    end

    // Storage write port: sequencer has priority, runtime writes only when idle
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = '0;
        mem_data_s = '0;
        if (init_we_s) begin
            mem_we_s   = 1'b1;
            mem_addr_s = init_addr_s;
            mem_data_s = init_data_s;
        end else if (wr_accept_s) begin
            mem_we_s   = 1'b1;
            mem_addr_s = bus.wr_key;
            mem_data_s = bus.wr_value;
        end else begin
            mem_we_s   = 1'b0;
        end
    end

    // Table storage; not cleared by reset because INIT rewrites every entry
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_data_s;
        end
    end

    // Registered read port and write-error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_value_r <= '0;
            rd_valid_r <= 1'b0;
            wr_err_r   <= 1'b0;
        end else begin
            wr_err_r <= wr_reject_s;
            if (!busy_s && bus.rd_en) begin
                rd_value_r <= rd_data_s;
                rd_valid_r <= 1'b1;
            end else begin
                rd_value_r <= '0;
                rd_valid_r <= 1'b0;
            end
        end
    end

    assign bus.rd_value = rd_value_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.wr_err   = wr_err_r;
    assign bus.busy     = busy_s;

endmodule
